// File: rtl/instruction_fetch_queue_pkg.sv
// Package: default sizing constants and entry layout for the instruction fetch queue.
//   DATA_W / PC_W / ADDR_W / DEPTH : default parameter values
//   fetch_entry_t                  : one queued {instruction, pc} pair at default widths
//   is_pow2()                      : elaboration helper for DEPTH legality checks
package instr_fetch_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PC_W   = 8;
    localparam int unsigned ADDR_W = 16;
    localparam int unsigned DEPTH  = 4;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

    // True for powers of two that are at least 2.
    function automatic bit is_pow2(input int unsigned v);
        return (v >= 2) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/instruction_fetch_queue_if.sv
// Interface: producer/consumer handshake bundle of the instruction fetch queue.
//   master : fetch unit + decode side (drives flush, push data, out_ready)
//   slave  : the queue itself (drives in_ready, head outputs, count)
interface instruction_fetch_queue_if #(
    parameter int unsigned DATA_W = instr_fetch_pkg::DATA_W,
    parameter int unsigned PC_W   = instr_fetch_pkg::PC_W,
    parameter int unsigned ADDR_W = instr_fetch_pkg::ADDR_W,
    parameter int unsigned DEPTH  = instr_fetch_pkg::DEPTH
);

    logic                         flush;
    logic                         in_valid;
    logic                         in_ready;
    logic [DATA_W-1:0]            instruction_in;
    logic [PC_W-1:0]              pc_count;
    logic                         out_valid;
    logic                         out_ready;
    logic [DATA_W-1:0]            instruction_out;
    logic [ADDR_W-1:0]            ram_pc_address_out;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output flush, in_valid, instruction_in, pc_count, out_ready,
        input  in_ready, out_valid, instruction_out, ram_pc_address_out, count
    );

    modport slave (
        input  flush, in_valid, instruction_in, pc_count, out_ready,
        output in_ready, out_valid, instruction_out, ram_pc_address_out, count
    );

endinterface

// File: rtl/instruction_fetch_queue_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers and occupancy count of a power-of-two FIFO.
//   clk, reset_n     : clock, asynchronous active-low reset
//   push, pop, flush : qualified enqueue / dequeue / discard-all strobes
//   wr_ptr, rd_ptr   : tail / head slot indices (wrap DEPTH-1 -> 0)
//   count, full, empty : occupancy and its derived flags
module fifo_ptr_ctrl #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    output logic [$clog2(DEPTH)-1:0]     wr_ptr,
    output logic [$clog2(DEPTH)-1:0]     rd_ptr,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    import instr_fetch_pkg::*;

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("fifo_ptr_ctrl: DEPTH must be a power of two and >= 2");
    end

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Power-of-two depth: natural overflow of the PtrW-bit add is the wrap.
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
            if (push && !pop)      count_d = count_q + CntW'(1);
            else if (pop && !push) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign wr_ptr = wr_ptr_q;
    assign rd_ptr = rd_ptr_q;
    assign count  = count_q;
    assign full   = (count_q == CntW'(DEPTH));
    assign empty  = (count_q == '0);

endmodule

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: FIFO of fetched {instruction, pc} pairs between fetch and decode.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : flush, push side (in_valid/in_ready/instruction_in/pc_count),
//                  pop side (out_valid/out_ready/instruction_out/ram_pc_address_out), count
// Handshake flags come only from registered occupancy, so no combinational path runs
// from out_ready to in_ready and a pushed entry is visible one cycle later.
module instruction_fetch_queue #(
    parameter int unsigned DATA_W = instr_fetch_pkg::DATA_W,
    parameter int unsigned PC_W   = instr_fetch_pkg::PC_W,
    parameter int unsigned ADDR_W = instr_fetch_pkg::ADDR_W,
    parameter int unsigned DEPTH  = instr_fetch_pkg::DEPTH
) (
    input  logic                        clk,
    input  logic                        reset_n,
    instruction_fetch_queue_if.slave    bus
);
    import instr_fetch_pkg::*;

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    if (PC_W > ADDR_W) begin : g_bad_widths
        $error("instruction_fetch_queue: PC_W must not exceed ADDR_W");
    end
    if (!is_pow2(DEPTH)) begin : g_bad_depth
        $error("instruction_fetch_queue: DEPTH must be a power of two and >= 2");
    end

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [PC_W-1:0]   pc;
    } entry_t;

    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic [CntW-1:0] count;
    logic            full, empty;
    logic            push, pop;
    entry_t          mem_q [DEPTH];
    entry_t          mem_d [DEPTH];
    entry_t          head;

    // Flush wins over both sides; full blocks a push even if a pop happens this cycle.
    assign push = bus.in_valid && !full && !bus.flush;
    assign pop  = !empty && bus.out_ready && !bus.flush;

    fifo_ptr_ctrl #(
        .DEPTH (DEPTH)
    ) u_ptr_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (bus.flush),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr] = '{instr: bus.instruction_in, pc: bus.pc_count};
        end
    end

    // Storage is left unreset; the empty mask below hides stale contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_comb begin
        head                   = mem_q[rd_ptr];
        bus.in_ready           = !full;
        bus.out_valid          = !empty;
        bus.count              = count;
        bus.instruction_out    = '0;
        bus.ram_pc_address_out = '0;
        if (!empty) begin
            bus.instruction_out    = head.instr;
            bus.ram_pc_address_out = ADDR_W'(head.pc);
        end
    end

endmodule

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 Parameter: DATA_W, 32, instruction word width in bits.
REQ-002 Parameter: PC_W, 8, incoming program-counter width in bits.
REQ-003 Parameter: ADDR_W, 16, RAM address width; PC_W <= ADDR_W SHALL hold (elaboration error otherwise).
REQ-004 Parameter: DEPTH, 4, queue entries; power of two, >= 2 (elaboration error otherwise).
REQ-005 Port: clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-006 Port: reset_n  input  1  reset, asynchronous and active-low.
REQ-007 Port: flush  input  1  synchronous discard of all queued entries (branch/redirect).
REQ-008 Port: in_valid  input  1  producer presents a fetched instruction this cycle.
REQ-009 Port: in_ready  output  1  queue accepts a push this cycle.
REQ-010 Port: instruction_in  input  DATA_W  fetched instruction word.
REQ-011 Port: pc_count  input  PC_W  PC of instruction_in.
REQ-012 Port: out_valid  output  1  head entry is available.
REQ-013 Port: out_ready  input  1  consumer takes the head entry this cycle.
REQ-014 Port: instruction_out  output  DATA_W  head instruction.
REQ-015 Port: ram_pc_address_out  output  ADDR_W  head PC, zero-extended to ADDR_W.
REQ-016 Port: count  output  $clog2(DEPTH+1)  number of occupied entries.

Function
REQ-017 Push SHALL occur when in_valid && in_ready && !flush; entry stores instruction_in and pc_count at the tail.
REQ-018 Pop SHALL occur when out_valid && out_ready && !flush; head advances by one.
REQ-019 in_ready SHALL equal (count != DEPTH), derived from registered state only; no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count != 0); latency from push to out_valid high is exactly 1 cycle; no same-cycle bypass.
REQ-021 Push and pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-022 When full, in_valid SHALL be back-pressured (in_ready low); a same-cycle pop does not enable a push that cycle.
REQ-023 When empty, instruction_out and ram_pc_address_out SHALL drive 0; otherwise they drive the head entry.
REQ-024 ram_pc_address_out SHALL be {(ADDR_W-PC_W) zeros, stored pc}.
REQ-025 Read/write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-026 flush SHALL dominate: next cycle count = 0, pointers equal, out_valid = 0; a push or pop asserted in the flush cycle is discarded/not performed.
REQ-027 Head entry and outputs SHALL remain stable while out_valid && !out_ready.

Reset
REQ-028 While reset_n = 0: count = 0, pointers = 0, out_valid = 0, in_ready = 1, instruction_out = 0, ram_pc_address_out = 0, independent of clk.
REQ-029 Reset asserted mid-operation SHALL discard all entries; storage array need not be reset.
REQ-030 First push SHALL be accepted on the first rising edge after reset_n deasserts.

Structure
REQ-031 Package instr_fetch_pkg SHALL hold default constants DATA_W, PC_W, ADDR_W, DEPTH and a packed typedef fetch_entry_t {instr, pc}.
REQ-032 Pointer/count logic SHALL live in sub-module fifo_ptr_ctrl (params DEPTH; inputs push, pop, flush; outputs wr_ptr, rd_ptr, count, full, empty).

Verification
REQ-033 Reset: reset_n low mid-stream with 3 entries -> count=0, out_valid=0, in_ready=1, outputs 0 immediately.
REQ-034 Order: push 0xDEADBEEF@pc 0x12, 0x00000013@pc 0x13, out_ready=1 -> outputs in order, ram_pc_address_out 0x0012 then 0x0013, out_valid high 1 cycle after first push.
REQ-035 Full: DEPTH=4, out_ready=0, push 5 words -> in_ready low after 4th, count=4, 5th held; then pop one -> 5th accepted next cycle.
REQ-036 Wrap: 10 push/pop cycles with simultaneous push+pop at count=2 -> count stays 2, outputs match input sequence across pointer wrap.
REQ-037 Flush: count=3, flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, flushed-cycle word never appears.
REQ-038 Width: PC_W=8, ADDR_W=16, pc 0xFF -> ram_pc_address_out 0x00FF.
